// File: rtl/row_uram_arbiter_pkg.sv
// Shared types and constants for the row-level URAM arbiter and the core-side URAM port.
package row_uram_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RELEASE
    } arb_state_t;

    localparam int URAM_ADDR_W       = 12;
    localparam int URAM_DATA_W       = 32;
    localparam int NUM_CORES_DEFAULT = 8;

    // Pointer width for an N-entry round-robin; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/row_uram_arbiter_picker.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping modulo N.
module rr_priority_picker #(
    parameter int N  = 8,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          valid
);

    // cand[gi] is the core examined at scan offset gi+1 from ptr.
    logic [PW:0]   sum  [N];
    logic [PW-1:0] cand [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            assign sum[gi]  = {1'b0, ptr} + (PW+1)'(gi + 1);
            assign cand[gi] = (sum[gi] >= (PW+1)'(N)) ? PW'(sum[gi] - (PW+1)'(N))
                                                      : PW'(sum[gi]);
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester is the last one written.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                idx   = cand[k];
                valid = 1'b1;
            end
        end
        if (valid) begin
            onehot = N'(1) << idx;
        end
    end

endmodule

// File: rtl/row_uram_arbiter.sv
// Row arbiter: round-robin exclusive URAM ownership, registered URAM mux and emptied broadcast.
module row_uram_arbiter #(
    parameter int NUM_CORES   = row_uram_arbiter_pkg::NUM_CORES_DEFAULT,
    parameter int URAM_ADDR_W = row_uram_arbiter_pkg::URAM_ADDR_W,
    parameter int URAM_DATA_W = row_uram_arbiter_pkg::URAM_DATA_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CORES-1:0]           i_core_req,
    input  logic [NUM_CORES-1:0]           i_core_locked,
    output logic [NUM_CORES-1:0]           o_core_grant,
    output logic                           o_uram_emptied,
    input  logic [NUM_CORES-1:0]           i_uram_en,
    input  logic [NUM_CORES*URAM_ADDR_W-1:0] i_uram_addr,
    input  logic [NUM_CORES*URAM_DATA_W-1:0] i_uram_wr_data,
    input  logic [NUM_CORES-1:0]           i_uram_wr_en,
    input  logic                           i_drain_done,
    output logic                           o_uram_en,
    output logic [URAM_ADDR_W-1:0]         o_uram_addr,
    output logic [URAM_DATA_W-1:0]         o_uram_wr_data,
    output logic                           o_uram_wr_en
);

    import row_uram_arbiter_pkg::*;

    localparam int PW = ptr_width(NUM_CORES);

    arb_state_t             state_reg;
    logic [NUM_CORES-1:0]   grant_reg;
    logic [PW-1:0]          rr_ptr_reg;
    logic                   uram_en_reg;
    logic                   uram_wr_en_reg;
    logic [URAM_ADDR_W-1:0] uram_addr_reg;
    logic [URAM_DATA_W-1:0] uram_wr_data_reg;
    logic                   emptied_reg;

    // Unpack the per-core URAM buses so the granted core can be selected by index.
    logic [URAM_ADDR_W-1:0] addr_arr [NUM_CORES];
    logic [URAM_DATA_W-1:0] data_arr [NUM_CORES];

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
            assign addr_arr[gi] = i_uram_addr[gi*URAM_ADDR_W +: URAM_ADDR_W];
            assign data_arr[gi] = i_uram_wr_data[gi*URAM_DATA_W +: URAM_DATA_W];
        end
    endgenerate

    logic [NUM_CORES-1:0] pick_onehot;
    logic [PW-1:0]        pick_idx;
    logic                 pick_valid;

    rr_priority_picker #(
        .N  (NUM_CORES),
        .PW (PW)
    ) u_picker (
        .req    (i_core_req),
        .ptr    (rr_ptr_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // rr_ptr doubles as the owner index while a grant is active.
    logic                   own_req;
    logic                   own_locked;
    logic                   own_en;
    logic                   own_wr_en;
    logic [URAM_ADDR_W-1:0] own_addr;
    logic [URAM_DATA_W-1:0] own_data;
    logic                   muxed_write;

    assign own_req     = i_core_req[rr_ptr_reg];
    assign own_locked  = i_core_locked[rr_ptr_reg];
    assign own_en      = i_uram_en[rr_ptr_reg];
    assign own_wr_en   = i_uram_wr_en[rr_ptr_reg];
    assign own_addr    = addr_arr[rr_ptr_reg];
    assign own_data    = data_arr[rr_ptr_reg];
    assign muxed_write = (state_reg == ARB_GRANT) && own_en && own_wr_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg        <= ARB_IDLE;
            grant_reg        <= '0;
            rr_ptr_reg       <= PW'(NUM_CORES - 1);
            uram_en_reg      <= 1'b0;
            uram_wr_en_reg   <= 1'b0;
            uram_addr_reg    <= '0;
            uram_wr_data_reg <= '0;
            emptied_reg      <= 1'b1;
        end else begin
            uram_en_reg      <= 1'b0;
            uram_wr_en_reg   <= 1'b0;
            uram_addr_reg    <= '0;
            uram_wr_data_reg <= '0;

            // A write in the same cycle as drain_done means fresh data is present.
            if (muxed_write) begin
                emptied_reg <= 1'b0;
            end else if (i_drain_done) begin
                emptied_reg <= 1'b1;
            end

            case (state_reg)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_reg  <= pick_onehot;
                        rr_ptr_reg <= pick_idx;
                        state_reg  <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    uram_en_reg      <= own_en;
                    uram_wr_en_reg   <= own_wr_en;
                    uram_addr_reg    <= own_addr;
                    uram_wr_data_reg <= own_data;
                    if (!own_req && !own_locked) begin
                        grant_reg <= '0;
                        state_reg <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    grant_reg <= '0;
                    state_reg <= ARB_IDLE;
                end
                default: begin
                    grant_reg <= '0;
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    assign o_core_grant   = grant_reg;
    assign o_uram_emptied = emptied_reg;
    assign o_uram_en      = uram_en_reg;
    assign o_uram_wr_en   = uram_wr_en_reg;
    assign o_uram_addr    = uram_addr_reg;
    assign o_uram_wr_data = uram_wr_data_reg;

endmodule

// File: tb/tb_row_uram_arbiter.sv
// Self-checking bench for row_uram_arbiter against a cycle-level ownership model.
module tb_row_uram_arbiter;

    localparam int N  = 8;
    localparam int AW = 12;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    core_req = '0;
    logic [N-1:0]    core_locked = '0;
    logic [N-1:0]    grant;
    logic            emptied;
    logic [N-1:0]    uram_en = '0;
    logic [N*AW-1:0] uram_addr = '0;
    logic [N*DW-1:0] uram_data = '0;
    logic [N-1:0]    uram_wr_en = '0;
    logic            drain_done = 1'b0;
    logic            out_en;
    logic [AW-1:0]   out_addr;
    logic [DW-1:0]   out_data;
    logic            out_wr_en;

    int errors = 0;
    int checks = 0;

    row_uram_arbiter #(
        .NUM_CORES   (N),
        .URAM_ADDR_W (AW),
        .URAM_DATA_W (DW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_core_req     (core_req),
        .i_core_locked  (core_locked),
        .o_core_grant   (grant),
        .o_uram_emptied (emptied),
        .i_uram_en      (uram_en),
        .i_uram_addr    (uram_addr),
        .i_uram_wr_data (uram_data),
        .i_uram_wr_en   (uram_wr_en),
        .i_drain_done   (drain_done),
        .o_uram_en      (out_en),
        .o_uram_addr    (out_addr),
        .o_uram_wr_data (out_data),
        .o_uram_wr_en   (out_wr_en)
    );

    always #5 clk = ~clk;

    // Model: who owns the URAM (-1 = nobody), last winner, one-cycle cooldown after release.
    int          m_owner;
    int          m_last;
    bit          m_cool;
    logic        m_en;
    logic        m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic        m_empty;

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_cool  = 1'b0;
        m_en    = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_empty = 1'b1;
    endtask

    task automatic model_step();
        bit wrote = 1'b0;
        m_en = 1'b0; m_wr = 1'b0; m_addr = '0; m_data = '0;
        if (m_owner >= 0) begin
            m_en   = uram_en[m_owner];
            m_wr   = uram_wr_en[m_owner];
            m_addr = uram_addr[m_owner*AW +: AW];
            m_data = uram_data[m_owner*DW +: DW];
            wrote  = uram_en[m_owner] && uram_wr_en[m_owner];
            if (!core_req[m_owner] && !core_locked[m_owner]) begin
                m_owner = -1;
                m_cool  = 1'b1;
            end
        end else if (m_cool) begin
            m_cool = 1'b0;
        end else begin
            for (int s = 1; s <= N; s++) begin
                int c = (m_last + s) % N;
                if (core_req[c]) begin
                    m_owner = c;
                    m_last  = c;
                    break;
                end
            end
        end
        if (wrote) m_empty = 1'b0;
        else if (drain_done) m_empty = 1'b1;
    endtask

    function automatic logic [N-1:0] exp_grant();
        return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        core_req = '0; core_locked = '0; uram_en = '0; uram_wr_en = '0;
        uram_addr = '0; uram_data = '0; drain_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (grant !== '0) begin errors++; $display("FAIL reset_grant cyc=%0d got=%h exp=00", i, grant); end
            checks++;
            if (out_en !== 1'b0) begin errors++; $display("FAIL reset_uram_en cyc=%0d got=%b exp=0", i, out_en); end
            checks++;
            if (emptied !== 1'b1) begin errors++; $display("FAIL reset_emptied cyc=%0d got=%b exp=1", i, emptied); end
        end
    endtask

    task automatic test_single_write();
        do_reset();
        core_req[3] = 1'b1;
        tick();
        checks++;
        if (grant !== 8'h08) begin errors++; $display("FAIL single_grant got=%h exp=08", grant); end
        uram_en[3] = 1'b1; uram_wr_en[3] = 1'b1;
        uram_addr[3*AW +: AW] = 12'h0A5;
        uram_data[3*DW +: DW] = 32'hDEADBEEF;
        tick();
        checks++;
        if ({out_en, out_wr_en, out_addr, out_data} !== {1'b1, 1'b1, 12'h0A5, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_uram got en=%b we=%b a=%h d=%h exp en=1 we=1 a=0a5 d=deadbeef",
                     out_en, out_wr_en, out_addr, out_data);
        end
        checks++;
        if (emptied !== 1'b0) begin errors++; $display("FAIL single_emptied got=%b exp=0", emptied); end
        clear_inputs();
        tick();
        checks++;
        if (grant !== '0) begin errors++; $display("FAIL single_release got=%h exp=00", grant); end
        tick();
        checks++;
        if (grant !== '0 || out_en !== 1'b0) begin
            errors++; $display("FAIL single_idle got grant=%h en=%b exp grant=00 en=0", grant, out_en);
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int held = 0;
        logic [N-1:0] prev = '0;
        do_reset();
        core_req = '1;
        for (int cyc = 0; cyc < 400 && order.size() < 9; cyc++) begin
            tick();
            checks++;
            if (grant !== exp_grant()) begin
                errors++; $display("FAIL rot_grant cyc=%0d got=%h exp=%h", cyc, grant, exp_grant());
            end
            checks++;
            if ($countones(grant) > 1) begin errors++; $display("FAIL rot_overlap got=%h exp=onehot", grant); end
            if (grant != '0 && prev == '0) begin
                for (int k = 0; k < N; k++) if (grant[k]) order.push_back(k);
            end
            if (grant != '0) held++; else held = 0;
            if (grant != '0 && held == 4) core_req = ~grant;
            if (grant == '0) core_req = '1;
            prev = grant;
        end
        checks++;
        if (order.size() != 9) begin
            errors++; $display("FAIL rot_timeout got=%0d grants exp=9", order.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (order[i] != i % N) begin
                    errors++; $display("FAIL rot_order pos=%0d got=%0d exp=%0d", i, order[i], i % N);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_locked();
        do_reset();
        core_req[5] = 1'b1;
        tick();
        checks++;
        if (grant !== 8'h20) begin errors++; $display("FAIL lock_grant got=%h exp=20", grant); end
        core_req[5] = 1'b0; core_locked[5] = 1'b1; core_req[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (grant !== 8'h20) begin errors++; $display("FAIL lock_hold cyc=%0d got=%h exp=20", i, grant); end
        end
        core_locked[5] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (grant !== '0) begin errors++; $display("FAIL lock_release cyc=%0d got=%h exp=00", i, grant); end
        end
        tick();
        checks++;
        if (grant !== 8'h04) begin errors++; $display("FAIL lock_next got=%h exp=04", grant); end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_mux_isolation();
        logic [AW-1:0] want_addr;
        logic [DW-1:0] want_data;
        logic want_en, want_we;
        do_reset();
        core_req[6] = 1'b1;
        tick();
        checks++;
        if (grant !== 8'h40) begin errors++; $display("FAIL iso_grant got=%h exp=40", grant); end
        for (int i = 0; i < 10; i++) begin
            uram_addr = {N{12'h000}} ^ {$urandom, $urandom, $urandom};
            for (int k = 0; k < N; k++) uram_data[k*DW +: DW] = $urandom;
            uram_en = N'($urandom); uram_wr_en = N'($urandom);
            uram_en[1] = 1'b1; uram_wr_en[1] = 1'b1;
            want_en = uram_en[6]; want_we = uram_wr_en[6];
            want_addr = uram_addr[6*AW +: AW]; want_data = uram_data[6*DW +: DW];
            tick();
            checks++;
            if ({out_en, out_wr_en, out_addr, out_data} !== {want_en, want_we, want_addr, want_data}) begin
                errors++;
                $display("FAIL iso_uram cyc=%0d got en=%b we=%b a=%h d=%h exp en=%b we=%b a=%h d=%h",
                         i, out_en, out_wr_en, out_addr, out_data, want_en, want_we, want_addr, want_data);
            end
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_drain_and_reset();
        do_reset();
        core_req[4] = 1'b1;
        tick();
        uram_en[4] = 1'b1; uram_wr_en[4] = 1'b1; drain_done = 1'b1;
        tick();
        checks++;
        if (emptied !== 1'b0) begin errors++; $display("FAIL drain_clash got=%b exp=0", emptied); end
        uram_en[4] = 1'b0; uram_wr_en[4] = 1'b0; drain_done = 1'b0;
        tick();
        checks++;
        if (emptied !== 1'b0) begin errors++; $display("FAIL drain_hold got=%b exp=0", emptied); end
        drain_done = 1'b1;
        tick();
        checks++;
        if (emptied !== 1'b1) begin errors++; $display("FAIL drain_set got=%b exp=1", emptied); end
        drain_done = 1'b0;
        uram_en[4] = 1'b1; uram_wr_en[4] = 1'b1;
        tick();
        checks++;
        if (out_wr_en !== 1'b1 || grant !== 8'h10) begin
            errors++; $display("FAIL midgrant_pre got we=%b grant=%h exp we=1 grant=10", out_wr_en, grant);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== '0 || out_wr_en !== 1'b0) begin
            errors++; $display("FAIL async_reset got grant=%h we=%b exp grant=00 we=0", grant, out_wr_en);
        end
        @(posedge clk);
        #3;
        clear_inputs();
        reset = 1'b0;
        model_reset();
        core_req = '1;
        @(posedge clk);
        #1;
        model_step();
        checks++;
        if (grant !== 8'h01) begin errors++; $display("FAIL post_reset_first got=%h exp=01", grant); end
        clear_inputs();
        repeat (4) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                core_req[k]    = ($urandom_range(0, 3) == 0);
                core_locked[k] = ($urandom_range(0, 7) == 0);
                uram_addr[k*AW +: AW] = AW'($urandom);
                uram_data[k*DW +: DW] = $urandom;
            end
            uram_en    = N'($urandom);
            uram_wr_en = N'($urandom);
            drain_done = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (grant !== exp_grant()) begin
                errors++; $display("FAIL rnd_grant cyc=%0d got=%h exp=%h", cyc, grant, exp_grant());
            end
            checks++;
            if ({out_en, out_wr_en, out_addr, out_data} !== {m_en, m_wr, m_addr, m_data}) begin
                errors++;
                $display("FAIL rnd_uram cyc=%0d got en=%b we=%b a=%h d=%h exp en=%b we=%b a=%h d=%h",
                         cyc, out_en, out_wr_en, out_addr, out_data, m_en, m_wr, m_addr, m_data);
            end
            checks++;
            if (emptied !== m_empty) begin
                errors++; $display("FAIL rnd_emptied cyc=%0d got=%b exp=%b", cyc, emptied, m_empty);
            end
        end
        clear_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_write();
        test_rotation();
        test_locked();
        test_mux_isolation();
        test_drain_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
